// File: rtl/if_fetch_ctrl_pkg.sv
// rtl/if_fetch_ctrl_pkg.sv - shared opcode and control encodings for the IF stage
//
// Contents:
//   pc_sel_e        : IF PC-mux select encodings (shared with the IF PC mux)
//   OPC_*           : RV32 major opcodes that redirect fetch
//   fetch_state_e   : fetch sequencer states
//   redirect_sel()  : PC select for a non-stalled cycle, from the EXE instruction
package if_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        PC_SEL_RESET = 3'd0,
        PC_SEL_HOLD  = 3'd1,
        PC_SEL_PLUS4 = 3'd2,
        PC_SEL_ALU   = 3'd3,
        PC_SEL_JUMP  = 3'd4
    } pc_sel_e;

    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } fetch_state_e;

    // JAL outranks JALR/branch; a not-taken branch falls through to PLUS4.
    function automatic pc_sel_e redirect_sel(input logic [6:0] opcode, input logic br_taken);
        pc_sel_e sel;
        if (opcode == OPC_JAL) begin
            sel = PC_SEL_JUMP;
        end else if ((opcode == OPC_JALR) || ((opcode == OPC_BRANCH) && br_taken)) begin
            sel = PC_SEL_ALU;
        end else begin
            sel = PC_SEL_PLUS4;
        end
        return sel;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_sat_counter.sv
// rtl/if_fetch_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clk   : clock
//   clr   : synchronous clear (highest priority)
//   inc   : increment by one; holds once all ones is reached
//   count : current value
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage fetch sequencer: PC select, flush and boot sequencing
//
// Optional feature macro: IF_FETCH_CTRL_PERF_EN (adds flush_cnt / stall_cnt).
//
// Ports:
//   clk         : clock
//   rst         : synchronous active-high reset
//   inst_exe    : instruction currently in EXE (bubble = 0)
//   br_taken    : branch-compare result for inst_exe
//   stall_req   : downstream stall; PC must hold
//   pc_sel      : IF PC-mux select (pc_sel_e encoding)
//   flush       : squash the instruction leaving IF (should_br)
//   fetch_valid : IF instruction is architecturally valid this cycle
//   flush_cnt   : RUN/STALL cycles with flush set (perf build only)
//   stall_cnt   : cycles with pc_sel = HOLD (perf build only)
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_exe,
    input  logic        br_taken,
    input  logic        stall_req,
    output logic [2:0]  pc_sel,
    output logic        flush,
    output logic        fetch_valid
`ifdef IF_FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] flush_cnt,
    output logic [31:0] stall_cnt
`endif
);

    // A zero-length boot would never let the synchronous IMEM read prime.
    localparam int          BOOT_EFF  = (BOOT_CYCLES < 1) ? 1 : BOOT_CYCLES;
    localparam logic [15:0] BOOT_LAST = 16'(BOOT_EFF - 1);

    fetch_state_e state, state_next;
    logic [15:0]  boot_cnt, boot_cnt_next;
    pc_sel_e      sel;

    // Only the opcode field steers fetch.
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst_exe[31:7];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_BOOT;
            boot_cnt <= '0;
        end else begin
            state    <= state_next;
            boot_cnt <= boot_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        boot_cnt_next = boot_cnt;
        sel           = PC_SEL_RESET;
        flush         = 1'b1;
        fetch_valid   = 1'b0;

        unique case (state)
            ST_BOOT: begin
                boot_cnt_next = boot_cnt + 16'd1;
                if (boot_cnt == BOOT_LAST) begin
                    state_next = ST_RUN;
                end
            end

            // RUN and STALL differ only in where they came from: EXE is frozen
            // during a stall, so the release cycle re-evaluates the same
            // instruction and acts on its redirect exactly once.
            ST_RUN, ST_STALL: begin
                if (stall_req) begin
                    sel        = PC_SEL_HOLD;
                    flush      = 1'b0;
                    state_next = ST_STALL;
                end else begin
                    sel         = redirect_sel(inst_exe[6:0], br_taken);
                    flush       = (sel != PC_SEL_PLUS4);
                    fetch_valid = (sel == PC_SEL_PLUS4);
                    state_next  = ST_RUN;
                end
            end

            default: begin
                state_next = ST_BOOT;
            end
        endcase

        // While reset is asserted the PC is parked regardless of the old state.
        if (rst) begin
            sel         = PC_SEL_RESET;
            flush       = 1'b1;
            fetch_valid = 1'b0;
        end
    end

    assign pc_sel = sel;

`ifdef IF_FETCH_CTRL_PERF_EN
    logic flush_inc, stall_inc;

    // Boot-time flushes are not pipeline events, so only RUN/STALL count.
    assign flush_inc = flush && !rst && (state != ST_BOOT);
    assign stall_inc = (sel == PC_SEL_HOLD);

    sat_counter #(.WIDTH(32)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );
`endif

endmodule
